// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, 1-cycle-latency imem requests, 2-entry return FIFO, redirect squash.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        inflight;
  logic [1:0]  count;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        pop;
  logic        push;
  logic [2:0]  occ;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign id_valid  = (count != 2'd0);
  assign pop       = id_valid & id_ready;
  assign push      = inflight & ~redirect_valid;
  assign occ       = {1'b0, count} + {2'b00, inflight};
  // occupancy after this cycle's pop must leave room for the word being requested
  assign imem_req  = rst & ~redirect_valid & (occ < (3'd2 + {2'b00, pop}));
  assign imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      req_pc      <= 32'h0;
      inflight    <= 1'b0;
      count       <= 2'd0;
      s_instr     <= 32'h0;
      s_pc        <= 32'h0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      if (redirect_valid) begin
        pc    <= {redirect_pc[31:2], 2'b00};
        count <= 2'd0;
      end else if (pop && push) begin
        if (count == 2'd2) begin
          id_instr    <= s_instr;
          id_pc       <= s_pc;
          id_pc_plus4 <= s_pc + 32'd4;
          s_instr     <= imem_rdata;
          s_pc        <= req_pc;
        end else begin
          id_instr    <= imem_rdata;
          id_pc       <= req_pc;
          id_pc_plus4 <= req_pc + 32'd4;
        end
      end else if (pop) begin
        if (count == 2'd2) begin
          id_instr    <= s_instr;
          id_pc       <= s_pc;
          id_pc_plus4 <= s_pc + 32'd4;
        end
        count <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          id_instr    <= imem_rdata;
          id_pc       <= req_pc;
          id_pc_plus4 <= req_pc + 32'd4;
        end else begin
          s_instr <= imem_rdata;
          s_pc    <= req_pc;
        end
        count <= count + 2'd1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= 32'h0;
      perf_bubbles <= 32'h0;
    end else begin
      if (pop)
        perf_fetched <= perf_fetched + 32'd1;
      if (id_ready && !id_valid)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirects, async reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [0:1023];

  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  always @(negedge clk)
    if (rst && dut.count == 2'd3) begin
      n_fail++;
      $display("FAIL count_overflow: count=%0d required<=2", dut.count);
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // leaves the bench in the first cycle after release, with rst just deasserted
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    id_ready = 1'b0; redirect_valid = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    n_tests++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", id_instr); end
    n_tests++; if (id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h want 0", id_pc_plus4); end
    step(); rst = 1'b1;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_fail++; $display("FAIL c1_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    step(); @(negedge clk);
    n_tests++; if (imem_addr !== 10'd1 || id_valid !== 1'b0) begin n_fail++; $display("FAIL c2: got addr=%h valid=%b want 1/0", imem_addr, id_valid); end
    step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h1000_0000 || id_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL c3_first: got v=%b pc=%h instr=%h pc4=%h want 1/0/10000000/4", id_valid, id_pc, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    do_reset();
    step(); step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== 32'h1000_0000 + 32'(i)) begin
        n_fail++; $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h want pc=%h", i, id_valid, id_pc, id_instr, 32'(4 * i));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'h1000_0008) begin
        n_fail++; $display("FAIL hold[%0d]: got req=%b v=%b pc=%h instr=%h want 0/1/20/10000008", i, imem_req, id_valid, id_pc, id_instr);
      end
      step();
    end
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'h20 + 32'(4 * i) || id_instr !== 32'h1000_0008 + 32'(i)) begin
        n_fail++; $display("FAIL resume[%0d]: got v=%b pc=%h instr=%h want pc=%h", i, id_valid, id_pc, id_instr, 32'h20 + 32'(4 * i));
      end
      step();
    end
`ifdef FETCH_PERF_EN
    @(negedge clk);
    n_tests++; if (perf_fetched !== 32'd14) begin n_fail++; $display("FAIL perf_fetched: got %0d want 14", perf_fetched); end
    n_tests++; if (perf_bubbles !== 32'd2) begin n_fail++; $display("FAIL perf_bubbles: got %0d want 2", perf_bubbles); end
`endif
  endtask

  task automatic test_redirect_full();
    // head 0x38 waiting, word for 0x3C in flight
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", imem_req); end
    step(); redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'd16) begin
      n_fail++; $display("FAIL redir_restart: got v=%b req=%b addr=%h want 0/1/10", id_valid, imem_req, imem_addr);
    end
    step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap: got v=%b pc=%h want 0", id_valid, id_pc); end
    step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h1000_0010) begin
      n_fail++; $display("FAIL redir_first: got v=%b pc=%h instr=%h want 1/40/10000010", id_valid, id_pc, id_instr);
    end
    step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h44) begin n_fail++; $display("FAIL redir_second: got v=%b pc=%h want 1/44", id_valid, id_pc); end
  endtask

  task automatic test_redirect_pop();
    id_ready = 1'b1;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h83;
    @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rp_pop: got v=%b pc=%h req=%b want 1/8/0", id_valid, id_pc, imem_req);
    end
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h20) begin
      n_fail++; $display("FAIL rp_addr: got v=%b req=%b addr=%h want 0/1/20", id_valid, imem_req, imem_addr);
    end
    step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rp_gap: got v=%b pc=%h want 0", id_valid, id_pc); end
    step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_instr !== 32'h1000_0020 || id_pc_plus4 !== 32'h84) begin
      n_fail++; $display("FAIL rp_next: got v=%b pc=%h instr=%h pc4=%h want 1/80/10000020/84", id_valid, id_pc, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_back_to_back();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req0: got %b want 0", imem_req); end
    step(); redirect_pc = 32'h204;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_req1: got req=%b v=%b want 0/0", imem_req, id_valid); end
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 10'h81) begin n_fail++; $display("FAIL b2b_addr: got req=%b addr=%h want 1/81", imem_req, imem_addr); end
    step(); step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h204 || id_instr !== 32'h1000_0081) begin
      n_fail++; $display("FAIL b2b_first: got v=%b pc=%h instr=%h want 1/204/10000081", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    n_tests++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_drop: got v=%b req=%b want 0/0", id_valid, imem_req); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin
      n_fail++; $display("FAIL arst_perf: got fetched=%0d bubbles=%0d want 0/0", perf_fetched, perf_bubbles);
    end
`endif
    step(); step(); rst = 1'b1;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_fail++; $display("FAIL arst_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    step(); step(); @(negedge clk);
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h1000_0000) begin
      n_fail++; $display("FAIL arst_refetch: got v=%b pc=%h instr=%h want 1/0/10000000", id_valid, id_pc, id_instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
